wavetable_fetch: RTL and testbench

- Oscillator front end that sits directly upstream of the linear interpolator.
- On each sample tick it advances an N-bit phase accumulator, splits the pre-advance phase into a table index and a fractional ratio, and reads two adjacent samples from an external synchronous-read wavetable memory.
- It presents the (a, b, ratio) triple with a one-cycle valid strobe. The interpolator consumes this triple combinationally.

---
 rtl/wavetable_fetch.sv | 145 ++++++++++++++
 tb/tb_wavetable_fetch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wavetable_fetch.sv
// Wavetable oscillator front end: phase accumulator plus a two-read fetch that presents (a, b, ratio) to the interpolator.
// Optional sticky overrun flag for dropped ticks when WAVETABLE_FETCH_OVERRUN_EN is defined.
module wavetable_fetch #(
  parameter int INPUT_BITS      = 16,
  parameter int RATIO_FRAC_BITS = 8,
  parameter int TABLE_BITS      = 8,
  parameter int PHASE_BITS      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_tick,
  input  logic [PHASE_BITS-1:0]      increment,
  input  logic                       phase_reset,
  output logic [TABLE_BITS-1:0]      mem_addr,
  output logic                       mem_rd,
  input  logic [INPUT_BITS-1:0]      mem_q,
  output logic [INPUT_BITS-1:0]      a,
  output logic [INPUT_BITS-1:0]      b,
  output logic [RATIO_FRAC_BITS-1:0] ratio,
  output logic                       valid,
  output logic                       busy
`ifdef WAVETABLE_FETCH_OVERRUN_EN
  ,
  output logic                       overrun
`endif
);

  if (PHASE_BITS < TABLE_BITS + RATIO_FRAC_BITS) begin : g_param_check
    $error("wavetable_fetch: PHASE_BITS must be >= TABLE_BITS + RATIO_FRAC_BITS");
  end

  typedef enum logic [1:0] {IDLE, ADDR_B, CAP_A, CAP_B} state_t;

  state_t                     state_q, state_d;
  logic [PHASE_BITS-1:0]      phase_q, phase_d;
  logic [PHASE_BITS-1:0]      snap;
  logic [TABLE_BITS-1:0]      idx_q, idx_d;
  logic [RATIO_FRAC_BITS-1:0] ratio_lat_q, ratio_lat_d;
  logic [INPUT_BITS-1:0]      a_hold_q, a_hold_d;
  logic [INPUT_BITS-1:0]      a_q, a_d, b_q, b_d;
  logic [RATIO_FRAC_BITS-1:0] ratio_q, ratio_d;
  logic                       valid_q, valid_d;
  logic [TABLE_BITS-1:0]      mem_addr_q, mem_addr_d;
  logic                       mem_rd_q, mem_rd_d;
  logic                       busy_q, busy_d;
  logic                       ovr_q, ovr_d;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    ratio_lat_d = ratio_lat_q;
    a_hold_d    = a_hold_q;
    a_d         = a_q;
    b_d         = b_q;
    ratio_d     = ratio_q;
    valid_d     = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    ovr_d       = ovr_q | (sample_tick & (state_q != IDLE));
    // Hard-sync zeroes the snapshot too, so a coincident tick fetches from 0 and lands on increment.
    snap        = phase_reset ? '0 : phase_q;
    if (phase_reset) phase_d = '0;

    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          phase_d     = snap + increment;
          idx_d       = snap[PHASE_BITS-1 -: TABLE_BITS];
          ratio_lat_d = snap[PHASE_BITS-TABLE_BITS-1 -: RATIO_FRAC_BITS];
          mem_addr_d  = snap[PHASE_BITS-1 -: TABLE_BITS];
          mem_rd_d    = 1'b1;
          state_d     = ADDR_B;
        end
      end
      ADDR_B: begin
        mem_addr_d = idx_q + TABLE_BITS'(1);
        mem_rd_d   = 1'b1;
        state_d    = CAP_A;
      end
      CAP_A: begin
        a_hold_d = mem_q;
        mem_rd_d = 1'b0;
        state_d  = CAP_B;
      end
      CAP_B: begin
        a_d     = a_hold_q;
        b_d     = mem_q;
        ratio_d = ratio_lat_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      idx_q       <= '0;
      ratio_lat_q <= '0;
      a_hold_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ratio_q     <= '0;
      valid_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      ratio_lat_q <= ratio_lat_d;
      a_hold_q    <= a_hold_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ratio_q     <= ratio_d;
      valid_q     <= valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign a        = a_q;
  assign b        = b_q;
  assign ratio    = ratio_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
`ifdef WAVETABLE_FETCH_OVERRUN_EN
  assign overrun  = ovr_q;
`else
  logic unused_ovr;
  assign unused_ovr = ovr_q;
`endif

endmodule

// File: tb/tb_wavetable_fetch.sv
// Scoreboard bench for wavetable_fetch: a reference oscillator model predicts each (a, b, ratio) triple.
module tb_wavetable_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic [31:0] increment = '0;
  logic        phase_reset = 1'b0;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_q = '0;
  logic [15:0] a, b;
  logic [7:0]  ratio;
  logic        valid, busy;
`ifdef WAVETABLE_FETCH_OVERRUN_EN
  logic        overrun;
`endif

  wavetable_fetch dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .increment(increment),
    .phase_reset(phase_reset), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_q(mem_q),
    .a(a), .b(b), .ratio(ratio), .valid(valid), .busy(busy)
`ifdef WAVETABLE_FETCH_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] tbl(input int k);
    return 16'((k & 255) * 16'h0101);
  endfunction

  // Synchronous-read wavetable: data appears one edge after address/enable are sampled.
  always @(posedge clk) if (mem_rd) mem_q <= tbl(int'(mem_addr));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  r;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: phase, cycles left in the current fetch, fetched index, sticky overrun.
  logic [31:0] m_phase = '0;
  int          m_left = 0;
  int          m_idx = 0;
  bit          m_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=a%0h/b%0h/r%0h required=no valid", a, b, ratio);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_a", {16'h0, a}, {16'h0, e.a});
        chk("valid_b", {16'h0, b}, {16'h0, e.b});
        chk("valid_ratio", {24'h0, ratio}, {24'h0, e.r});
      end
    end
  end

  // One clock of stimulus: check the cycle's observable state against the model, then drive and advance.
  task automatic step(input bit tick, input logic [31:0] inc, input bit pr);
    logic [31:0] snap;
    bit acc;
    exp_t e;
    @(negedge clk);
    chk("busy", {31'h0, busy}, {31'h0, (m_left != 0)});
    if (m_left == 3) begin
      chk("mem_addr_a", {24'h0, mem_addr}, 32'(m_idx));
      chk("mem_rd_a", {31'h0, mem_rd}, 32'd1);
    end else if (m_left == 2) begin
      chk("mem_addr_b", {24'h0, mem_addr}, 32'((m_idx + 1) % 256));
      chk("mem_rd_b", {31'h0, mem_rd}, 32'd1);
    end else begin
      chk("mem_rd_idle", {31'h0, mem_rd}, 32'd0);
    end
`ifdef WAVETABLE_FETCH_OVERRUN_EN
    chk("overrun", {31'h0, overrun}, {31'h0, m_ovr});
`endif
    sample_tick = tick;
    increment   = inc;
    phase_reset = pr;
    acc  = tick && (m_left == 0);
    snap = pr ? 32'h0 : m_phase;
    if (acc) begin
      m_idx = int'(snap / 32'h0100_0000);
      e.a = tbl(m_idx);
      e.b = tbl(m_idx + 1);
      e.r = 8'((snap / 32'h0001_0000) % 256);
      exp_q.push_back(e);
      m_phase = snap + inc;
      m_left = 3;
    end else begin
      if (pr) m_phase = 32'h0;
      if (m_left > 0) begin
        m_left--;
        if (tick) m_ovr = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear immediately and any in-flight fetch is dropped.
  task automatic do_reset();
    @(negedge clk);
    sample_tick = 1'b0;
    phase_reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_a", {16'h0, a}, 32'h0);
    chk("rst_b", {16'h0, b}, 32'h0);
    chk("rst_ratio", {24'h0, ratio}, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
`ifdef WAVETABLE_FETCH_OVERRUN_EN
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
`endif
    exp_q.delete();
    m_phase = '0;
    m_left  = 0;
    m_ovr   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    do_reset();

    // Integer-step fetches: T[0],T[1] then T[1],T[2].
    step(1'b1, 32'h0100_0000, 1'b0); idle(3);
    step(1'b1, 32'h0100_0000, 1'b0); idle(4);

    // Half-step increment gives ratio 0x80 on the second fetch.
    do_reset();
    step(1'b1, 32'h0080_0000, 1'b0); idle(3);
    step(1'b1, 32'h0080_0000, 1'b0); idle(4);

    // Top-of-table wrap in both the read address and the accumulator.
    do_reset();
    step(1'b1, 32'hFF40_0000, 1'b0); idle(3);
    step(1'b1, 32'hFF40_0000, 1'b0); idle(3);
    step(1'b1, 32'h0100_0000, 1'b0); idle(4);

    // Back-to-back ticks: only the first is accepted.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0300_0000, 1'b0);
    idle(3);
    step(1'b1, 32'h0100_0000, 1'b0); idle(4);

    // Hard-sync coincident with a tick, then hard-sync during the capture of a fetch.
    do_reset();
    step(1'b1, 32'h8000_0000, 1'b0); idle(3);
    step(1'b1, 32'h1234_5678, 1'b1); idle(3);
    step(1'b1, 32'h0100_0000, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    idle(2);
    step(1'b1, 32'h0100_0000, 1'b0); idle(4);

    // Reset during the first-sample capture aborts the fetch; next fetch starts at phase 0.
    step(1'b1, 32'h4321_0000, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    do_reset();
    idle(5);
    step(1'b1, 32'h0100_0000, 1'b0); idle(4);

    // Randomised traffic with occasional hard-sync and mid-fetch reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step($urandom_range(0, 99) < 45, $urandom, $urandom_range(0, 99) < 5);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1'b0, 32'h0, 1'b0);
    chk("drain_pending", 32'(exp_q.size()), 32'h0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
